imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader sitting directly upstream of the fetch stage. It accepts a framed byte stream from a host link, assembles little-endian 32-bit instruction words, and drives the fetch stage's instruction-memory write port (`i_wen`/`i_wdata`) plus a word address. It holds the rest of the pipeline in reset through `o_core_rst_n` until a complete, checksum-valid image has been written.

## Interface
- `MAX_WORDS`, 1024: largest image accepted, in 32-bit words.
- `ADDR_W`, 10: word-address width; must satisfy 2^ADDR_W >= MAX_WORDS.

- `clk`  in  1  core clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `i_start`  in  1  one-cycle pulse; arms or re-arms a load.
- `i_s_data`  in  8  stream byte.
- `i_s_valid`  in  1  `i_s_data` valid.
- `o_s_ready`  out  1  loader accepts a byte this cycle.
- `o_wen`  out  `IM_DATA_BYTES` (4)  instruction-memory byte write enables.
- `o_wdata`  out  32  instruction word.
- `o_waddr`  out  `ADDR_W`  word address of the write.
- `o_core_rst_n`  out  1  active-low reset to the pipeline stages.
- `o_busy`  out  1  load in progress.
- `o_done`  out  1  image loaded and verified.
- `o_err`  out  1  load rejected.

## Operation
- Frame format:
  - LEN_LO, LEN_HI: 16-bit word count N, little-endian.
  - 4·N payload bytes: each word is sent LSB first.
  - One CSUM byte: the XOR of all payload bytes. The length bytes are excluded.
- Handshake: a byte is consumed on any cycle where `i_s_valid & o_s_ready`. `i_s_data` is ignored otherwise.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR.
  - IDLE: wait for `i_start`, then go to LEN_LO.
  - LEN_LO: on accept, go to LEN_HI.
  - LEN_HI: on accept, check N.
    - N == 0 or N > MAX_WORDS: go to ERROR.
    - Otherwise go to DATA, clearing the word address, byte counter and checksum.
  - DATA: on each accept:
    - shift the byte into the assembly register at lane = byte counter;
    - XOR it into the running checksum;
    - on the 4th byte, issue a write;
    - after the N-th word's write is issued, go to CSUM.
  - CSUM: on accept, compare against the running checksum. Equal goes to DONE; unequal goes to ERROR.
  - DONE and ERROR: hold until `i_start`, then go to LEN_LO.
- Write issue:
  - `o_wen` = 4'b1111 for exactly one cycle.
  - `o_wdata` = the assembled word; `o_waddr` = the current word index.
  - The word index increments after each write.
- `i_start` in LEN_LO, LEN_HI, DATA or CSUM aborts the load:
  - go to LEN_LO;
  - drop any partial word;
  - clear counters and checksum;
  - `o_core_rst_n` stays 0.
  Words already written are not erased.
- `o_s_ready` = 1 only in LEN_LO, LEN_HI, DATA and CSUM.
- `o_busy` = 1 in the same four states.
- `o_done` = 1 only in DONE; `o_err` = 1 only in ERROR.
- `o_core_rst_n` = 1 only in DONE. It returns to 0 on the cycle after the state leaves DONE.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE;
  - `o_s_ready` 0, `o_wen` 0, `o_wdata` 0, `o_waddr` 0;
  - `o_core_rst_n` 0, `o_busy` 0, `o_done` 0, `o_err` 0.
- `rst` asserted mid-load: all state and outputs return to reset values immediately, with no clock required. No write is issued for a partial word.
- Write latency: `o_wen` pulses on the cycle after the accept edge of a word's 4th byte.
- Back-to-back writes: with `i_s_valid` held high, writes are spaced exactly 4 cycles apart.
- The last write's `o_wen` pulse coincides with the first cycle in CSUM.
- `o_s_ready` stays high through each write pulse. The design imposes no stall; the instruction memory must accept a write every 4 cycles.
- Done latency: `o_done`, `o_core_rst_n` = 1 on the cycle after the CSUM accept edge.
- Error latency: `o_err` = 1 on the cycle after the accept edge of the failing byte, either LEN_HI or CSUM.
- Valid gaps: arbitrary `i_s_valid` gaps leave the assembly register, counters and checksum unchanged.
- Width rule: the word index is `ADDR_W` bits and never wraps, because N <= MAX_WORDS is checked before DATA is entered.

## Test plan
- **Basic load.** Stimulus: `i_start`, then bytes 02 00 78 56 34 12 EF BE AD DE 2A.
  - Writes: (addr 0, 0x12345678) then (addr 1, 0xDEADBEEF), each `o_wen` = 1111 for 1 cycle, 4 cycles apart.
  - `o_done` = 1 and `o_core_rst_n` = 1 on the cycle after the 0x2A accept.
- **Bad checksum.** Same frame with last byte 2B.
  - Both writes still occur.
  - `o_err` = 1 on the cycle after the last accept.
  - `o_core_rst_n` stays 0.
- **Illegal length.**
  - Header 00 00: `o_err` = 1 after LEN_HI, and `o_s_ready` drops.
  - Header 01 04 (N = 1025): same response.
  - No `o_wen` activity in either case.
- **Backpressure.** Frame from the basic-load test with random 0–5 cycle `i_s_valid` gaps. Writes, addresses, data and done are identical to the basic-load test.
- **Reset mid-load.** Assert `rst` after 02 00 78 56.
  - All outputs read 0 in the same cycle.
  - A fresh `i_start` plus the full basic-load frame reproduces the basic-load result, with no stale bytes.
- **Restart.**
  - `i_start` in DONE: `o_core_rst_n` and `o_done` fall on the next cycle; `o_s_ready` = 1; address restarts at 0.
  - `i_start` pulsed mid-DATA: the partial word is dropped and the next frame loads correctly.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: parses a framed byte stream (length, little-endian payload, XOR checksum) into 32-bit instruction-memory writes and holds the core in reset until a verified image is in place.
// Latency: o_wen pulses one cycle after a word's 4th byte is accepted; o_done/o_err assert one cycle after the deciding byte is accepted.
// Backpressure: never stalls inside a load (o_s_ready high through every write), so the memory must absorb one write every 4 cycles.
module imem_loader #(
    parameter int MAX_WORDS = 1024,
    parameter int ADDR_W = 10,
    localparam int IM_DATA_BYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [7:0]               i_s_data,
    input  logic                     i_s_valid,
    output logic                     o_s_ready,
    output logic [IM_DATA_BYTES-1:0] o_wen,
    output logic [31:0]              o_wdata,
    output logic [ADDR_W-1:0]        o_waddr,
    output logic                     o_core_rst_n,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err
);

    // Largest legal word count, widened one bit so a 16-bit header compares cleanly.
    localparam logic [16:0]     MAX_N   = 17'(MAX_WORDS);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t          state_q;
    state_t          state_d;

    // Datapath state. Counters carry one extra bit so N == 2^ADDR_W never wraps.
    logic [7:0]      len_lo_q;
    logic [ADDR_W:0] len_q;
    logic [ADDR_W:0] word_cnt_q;
    logic [1:0]      byte_cnt_q;
    logic [31:0]     asm_q;
    logic [7:0]      csum_q;

    // Decoded per-cycle strobes.
    logic            accept;
    logic            lo_acc;
    logic            hi_acc;
    logic            data_acc;
    logic            csum_acc;
    logic            wr_fire;
    logic            last_word;
    logic            len_bad;
    logic            clr;
    logic [15:0]     len_n;

    // States in which the loader is mid-frame and takes bytes.
    function automatic logic loading(input state_t s);
        return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA) || (s == S_CSUM);
    endfunction

    // Byte-accept strobes; i_start outranks any byte presented in the same cycle.
    always_comb begin
        accept    = i_s_valid && loading(state_q) && !i_start;
        lo_acc    = accept && (state_q == S_LEN_LO);
        hi_acc    = accept && (state_q == S_LEN_HI);
        data_acc  = accept && (state_q == S_DATA);
        csum_acc  = accept && (state_q == S_CSUM);
        len_n     = {i_s_data, len_lo_q};
        len_bad   = (len_n == 16'd0) || ({1'b0, len_n} > MAX_N);
        last_word = ((word_cnt_q + CNT_ONE) == len_q);
        wr_fire   = data_acc && (byte_cnt_q == 2'd3);
    end

    // Next-state logic; clr wipes the partial word, counters and checksum.
    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        if (i_start) begin
            state_d = S_LEN_LO;
            clr     = 1'b1;
        end else begin
            case (state_q)
                S_LEN_LO: begin
                    if (lo_acc) begin
                        state_d = S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (hi_acc) begin
                        if (len_bad) begin
                            state_d = S_ERROR;
                        end else begin
                            state_d = S_DATA;
                            clr     = 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (wr_fire && last_word) begin
                        state_d = S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (csum_acc) begin
                        state_d = (i_s_data == csum_q) ? S_DONE : S_ERROR;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Status outputs registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_s_ready    <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_core_rst_n <= 1'b0;
        end else begin
            o_s_ready    <= loading(state_d);
            o_busy       <= loading(state_d);
            o_done       <= (state_d == S_DONE);
            o_err        <= (state_d == S_ERROR);
            o_core_rst_n <= (state_d == S_DONE);
        end
    end

    // Write port: one-cycle full-word strobe; data and address hold between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_wen   <= '0;
            o_wdata <= '0;
            o_waddr <= '0;
        end else begin
            o_wen <= wr_fire ? '1 : '0;
            if (wr_fire) begin
                o_wdata <= {i_s_data, asm_q[23:0]};
                o_waddr <= word_cnt_q[ADDR_W-1:0];
            end
        end
    end

    // Header capture: low length byte, then the validated word count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_lo_q <= '0;
            len_q    <= '0;
        end else begin
            if (lo_acc) begin
                len_lo_q <= i_s_data;
            end
            if (hi_acc && !len_bad) begin
                len_q <= len_n[ADDR_W:0];
            end
        end
    end

    // Word assembly, running checksum and word index; idle cycles leave them untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q      <= '0;
            csum_q     <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
        end else if (clr) begin
            asm_q      <= '0;
            csum_q     <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
        end else if (data_acc) begin
            asm_q[8*byte_cnt_q +: 8] <= i_s_data;
            csum_q                   <= csum_q ^ i_s_data;
            byte_cnt_q               <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
                word_cnt_q <= word_cnt_q + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random and directed frames against a frame-level reference model.
// Expected writes are queued when a frame is issued; a negedge monitor pops them on every o_wen pulse.
// Status (done/err/core reset) is checked one cycle after the deciding byte.
module tb_imem_loader;

    localparam int MAXW = 1024;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [7:0]  i_s_data;
    logic        i_s_valid;
    logic        o_s_ready;
    logic [3:0]  o_wen;
    logic [31:0] o_wdata;
    logic [9:0]  o_waddr;
    logic        o_core_rst_n;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    wr_t exp_wr[$];
    int  exp_cyc[$];
    int  wr_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_loader #(.MAX_WORDS(MAXW), .ADDR_W(10)) dut (
        .clk(clk),
        .rst(rst),
        .i_start(i_start),
        .i_s_data(i_s_data),
        .i_s_valid(i_s_valid),
        .o_s_ready(o_s_ready),
        .o_wen(o_wen),
        .o_wdata(o_wdata),
        .o_waddr(o_waddr),
        .o_core_rst_n(o_core_rst_n),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_err(o_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected write, in value and cycle.
    always @(negedge clk) begin : mon
        wr_t e;
        if (!rst) begin
            chk("core_rst_n_only_when_done", 64'(o_core_rst_n), 64'(o_done));
            if (o_wen != 4'h0) begin
                wr_cyc.push_back(cyc);
                chk("wen_value", 64'(o_wen), 64'(4'hF));
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", o_waddr, o_wdata);
                end else begin
                    e = exp_wr.pop_front();
                    chk("waddr", 64'(o_waddr), 64'(e.addr));
                    chk("wdata", 64'(o_wdata), 64'(e.data));
                end
                if (exp_cyc.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL write_timing: write at cycle %0d, expected none", cyc);
                end else begin
                    chk("write_latency", 64'(cyc), 64'(exp_cyc.pop_front()));
                end
            end
        end
    end

    // Reference model: decode the frame from its bytes and queue the writes it implies.
    // status: 0 = frame incomplete, 1 = done, 2 = error.
    task automatic model_frame(input bq_t fr, output int status);
        int n;
        int nb;
        logic [7:0] cs;
        status = 0;
        if (fr.size() < 2) return;
        n = int'({fr[1], fr[0]});
        if (n == 0 || n > MAXW) begin
            status = 2;
            return;
        end
        nb = fr.size() - 2;
        for (int w = 0; w < n && 4 * w + 3 < nb; w++) begin
            exp_wr.push_back('{addr: 10'(w),
                               data: {fr[2+4*w+3], fr[2+4*w+2], fr[2+4*w+1], fr[2+4*w]}});
        end
        if (nb >= 4 * n + 1) begin
            cs = 8'h00;
            for (int i = 0; i < 4 * n; i++) cs = cs ^ fr[2+i];
            status = (fr[2+4*n] == cs) ? 1 : 2;
        end
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    // Present one byte after a random idle gap and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int max_gap, input bit is_wr);
        int g;
        int t;
        bit rdy;
        g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        repeat (g) begin
            i_s_valid = 1'b0;
            i_s_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        i_s_valid = 1'b1;
        i_s_data  = b;
        t = 0;
        rdy = 1'b0;
        forever begin
            @(negedge clk);
            rdy = o_s_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            t++;
            if (t > 20) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: byte 0x%0h not accepted, ready %b, expected 1", b, rdy);
                break;
            end
        end
        if (rdy && is_wr) exp_cyc.push_back(cyc);
        i_s_valid = 1'b0;
        i_s_data  = 8'($urandom);
    endtask

    task automatic send_frame(input bq_t fr, input int max_gap);
        int n;
        bit ok;
        n  = (fr.size() >= 2) ? int'({fr[1], fr[0]}) : 0;
        ok = (n >= 1) && (n <= MAXW);
        foreach (fr[i]) begin
            send_byte(fr[i], max_gap, ok && i >= 2 && i < 2 + 4 * n && ((i - 2) % 4) == 3);
        end
    endtask

    // Issue a frame, then check status one cycle after its last accepted byte.
    task automatic run_frame(input bq_t fr, input int max_gap, input string tag);
        int st;
        model_frame(fr, st);
        send_frame(fr, max_gap);
        @(negedge clk);
        #1;
        if (st == 1)
            chk({tag, "_status_done"}, 64'({o_done, o_core_rst_n, o_err, o_busy, o_s_ready}), 64'(5'b11000));
        else if (st == 2)
            chk({tag, "_status_err"}, 64'({o_done, o_core_rst_n, o_err, o_busy, o_s_ready}), 64'(5'b00100));
        else
            chk({tag, "_status_busy"}, 64'({o_done, o_core_rst_n, o_err, o_busy, o_s_ready}), 64'(5'b00011));
        chk({tag, "_writes_missing"}, 64'(exp_wr.size()), 64'(0));
        chk({tag, "_write_times_missing"}, 64'(exp_cyc.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    function automatic bq_t make_frame(input int n, input bit bad);
        bq_t f;
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        f.push_back(8'(n));
        f.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            cs = cs ^ b;
            f.push_back(b);
        end
        if (bad) cs = cs ^ 8'(1 << $urandom_range(0, 7));
        f.push_back(cs);
        return f;
    endfunction

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t basic;
        bq_t bad;
        bq_t part;
        basic = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};

        rst = 1'b1;
        i_start = 1'b0;
        i_s_valid = 1'b0;
        i_s_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({o_s_ready, o_wen, o_wdata, o_waddr, o_core_rst_n, o_busy, o_done, o_err}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_after_reset", 64'({o_s_ready, o_busy, o_done, o_err, o_core_rst_n}), 64'(0));

        // Basic load, gapless: two writes 4 cycles apart, then done.
        pulse_start();
        wr_cyc.delete();
        run_frame(basic, 0, "basic");
        chk("basic_write_count", 64'(wr_cyc.size()), 64'(2));
        if (wr_cyc.size() == 2) chk("basic_write_spacing", 64'(wr_cyc[1] - wr_cyc[0]), 64'(4));
        repeat (3) @(posedge clk);
        #1;
        chk("done_holds", 64'({o_done, o_core_rst_n}), 64'(2'b11));

        // Restart from DONE: core goes back into reset, loader reopens at address 0.
        pulse_start();
        @(negedge clk);
        chk("restart_from_done", 64'({o_done, o_core_rst_n, o_s_ready, o_busy}), 64'(4'b0011));
        @(posedge clk);
        #1;
        run_frame(basic, 0, "reload");

        // Bad checksum: writes still happen, then error.
        bad = basic;
        bad[10] = 8'h2B;
        pulse_start();
        run_frame(bad, 0, "bad_csum");

        // Illegal lengths: 0 and MAX_WORDS+1.
        pulse_start();
        run_frame({8'h00, 8'h00}, 0, "len_zero");
        pulse_start();
        run_frame({8'h01, 8'h04}, 0, "len_1025");
        repeat (3) @(posedge clk);
        #1;
        chk("err_holds", 64'({o_err, o_s_ready, o_core_rst_n}), 64'(3'b100));

        // Backpressure: random valid gaps, same result.
        pulse_start();
        wr_cyc.delete();
        run_frame(basic, 5, "gaps");
        chk("gaps_write_count", 64'(wr_cyc.size()), 64'(2));

        // Asynchronous reset mid-load, then a clean reload.
        pulse_start();
        run_frame({8'h02, 8'h00, 8'h78, 8'h56}, 0, "pre_reset");
        #1;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", 64'({o_s_ready, o_wen, o_wdata, o_waddr, o_core_rst_n, o_busy, o_done, o_err}), 64'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        pulse_start();
        run_frame(basic, 0, "post_reset");

        // Abort mid-word with i_start: partial word dropped, next frame clean.
        part = basic[0:6];
        pulse_start();
        run_frame(part, 0, "partial");
        pulse_start();
        run_frame(basic, 0, "after_abort");

        // Largest legal image.
        pulse_start();
        run_frame(make_frame(MAXW, 1'b0), 0, "max_len");

        // Randomized frames: good, bad checksum, illegal length, aborted.
        for (int it = 0; it < 30; it++) begin
            int kind;
            int n;
            int cut;
            bq_t f;
            kind = int'($urandom_range(0, 9));
            pulse_start();
            if (kind == 0) begin
                n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAXW + 1, 65535));
                f = {8'(n), 8'(n >> 8)};
                run_frame(f, int'($urandom_range(0, 3)), "rnd_badlen");
            end else begin
                n = int'($urandom_range(1, 12));
                f = make_frame(n, kind <= 2);
                if (kind == 3) begin
                    cut = int'($urandom_range(3, f.size() - 1));
                    while (f.size() > cut) void'(f.pop_back());
                    run_frame(f, int'($urandom_range(0, 5)), "rnd_abort");
                end else begin
                    run_frame(f, int'($urandom_range(0, 5)), "rnd");
                end
            end
        end

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
